bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_if.sv | 21 ++
 rtl/bit_serializer.sv | 133 +++++++++++++
 tb/tb_bit_serializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Parallel-word handshake between a word producer and bit_serializer.
// Producer drives in_data/in_valid; the serializer answers with in_ready.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/bit_serializer.sv
// FIFO-buffered parallel-to-serial converter, gapless between queued words.
// Define BIT_SERIALIZER_LSB_FIRST_EN to emit LSB first (default MSB first).
module bit_serializer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   bit_serializer_if.slave        s_in,
   output logic                   ser_bit,
   output logic                   ser_valid,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             w_full;
   logic             w_empty;
   logic             w_last;
   logic             w_push;
   logic             w_pop;
   logic             w_head_bit;
   logic [WIDTH-1:0] w_shift_nxt;

   assign w_full  = (r_level == LVL_FULL);
   assign w_empty = (r_level == '0);
   assign w_last  = (r_cnt == CNT_LAST);

   // Ready depends on registered level only, so a full FIFO refuses
   // a push even on the edge that also pops.
   assign s_in.in_ready = !w_full;
   assign w_push = s_in.in_valid && !w_full;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
   assign w_head_bit  = r_shift[0];
   assign w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
`else
   assign w_head_bit  = r_shift[WIDTH-1];
   assign w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_last) begin
               if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_in.in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (w_pop) begin
         r_shift <= r_mem[r_rd_ptr];
         r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
         r_shift <= w_shift_nxt;
         r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign busy       = (r_state == SHIFT);
   assign ser_valid  = busy;
   assign ser_bit    = busy & w_head_bit;
   assign fifo_level = r_level;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: latency, ordering, backpressure, reset.
// Inputs change 1ns after rising edges; outputs are checked there too.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser_bit;
   logic       ser_valid;
   logic [2:0] fifo_level;
   logic       busy;
   int         n_tests = 0;
   int         n_fail = 0;
   logic       mon_q [$];
   logic [7:0] exp_q [$];

   bit_serializer_if #(.WIDTH(8)) bus ();

   bit_serializer #(.WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_in       (bus),
      .ser_bit    (ser_bit),
      .ser_valid  (ser_valid),
      .fifo_level (fifo_level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ser_valid === 1'b1) mon_q.push_back(ser_bit);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic bit_at(input logic [7:0] w, input int i);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      return w[i];
`else
      return w[7-i];
`endif
   endfunction

   task automatic exp_word(input string tag, input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
         chk({tag, "_bit"}, 32'(ser_bit), 32'(bit_at(w, i)));
         tick();
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(ser_valid), 32'd0);
      chk({tag, "_bit"}, 32'(ser_bit), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy !== 1'b0 || fifo_level !== 3'd0) && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 300), 32'd1);
      tick();
   endtask

   task automatic chk_stream(input string tag);
      logic [7:0] b;
      chk({tag, "_len"}, 32'(mon_q.size()), 32'(8 * exp_q.size()));
      for (int w = 0; w < exp_q.size(); w++) begin
         b = '0;
         for (int i = 0; i < 8; i++) begin
            if (mon_q.size() > 0) b[7-i] = mon_q.pop_front();
         end
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
         b = {<<{b}};
`endif
         chk($sformatf("%s_w%0d", tag, w), 32'(b), 32'(exp_q[w]));
      end
      mon_q.delete();
      exp_q.delete();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #12;
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk_idle("rst");

      // single word, first edge after reset release
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hFF;
      chk("a5_level", 32'(fifo_level), 32'd1);
      chk("a5_lat", 32'(ser_valid), 32'd0);
      tick();
      exp_word("a5", 8'hA5);
      chk_idle("a5_end");
      chk("a5_lvl0", 32'(fifo_level), 32'd0);

      // two words back to back, no gap
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h0A;
      tick();
      tick();
      bus.in_valid = 1'b0;
      chk("0a_level", 32'(fifo_level), 32'd1);
      exp_word("0a_1", 8'h0A);
      exp_word("0a_2", 8'h0A);
      chk_idle("0a_end");
      tick();
      mon_q.delete();

      // fill the FIFO, hold a sixth word under backpressure
      bus.in_valid = 1'b1;
      bus.in_data = 8'h11; tick();
      bus.in_data = 8'h01; tick();
      bus.in_data = 8'hA5; tick();
      bus.in_data = 8'h3C; tick();
      bus.in_data = 8'hC3; tick();
      chk("full_level", 32'(fifo_level), 32'd4);
      chk("full_ready", 32'(bus.in_ready), 32'd0);
      bus.in_data = 8'h80;
      tick();
      chk("full_refuse", 32'(fifo_level), 32'd4);
      begin
         int n = 0;
         while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
         end
         chk("ready_timeout", 32'(n < 50), 32'd1);
      end
      chk("freed_level", 32'(fifo_level), 32'd3);
      tick();
      bus.in_valid = 1'b0;
      chk("held_accept", 32'(fifo_level), 32'd4);
      exp_q = '{8'h11, 8'h01, 8'hA5, 8'h3C, 8'hC3, 8'h80};
      wait_idle("bp");
      chk_stream("bp");

      // push and pop on the same edge at level 2
      bus.in_valid = 1'b1;
      bus.in_data = 8'hAA; tick();
      bus.in_data = 8'hBB; tick();
      bus.in_data = 8'hCC; tick();
      bus.in_valid = 1'b0;
      chk("pp_pre", 32'(fifo_level), 32'd2);
      repeat (6) tick();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hDD;
      chk("pp_before", 32'(fifo_level), 32'd2);
      tick();
      bus.in_valid = 1'b0;
      chk("pp_after", 32'(fifo_level), 32'd2);
      exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      wait_idle("pp");
      chk_stream("pp");

      // reset during the 4th bit with two words queued
      bus.in_valid = 1'b1;
      bus.in_data = 8'hFF; tick();
      bus.in_data = 8'h12; tick();
      bus.in_data = 8'h34; tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("mid_valid", 32'(ser_valid), 32'd1);
      chk("mid_level", 32'(fifo_level), 32'd2);
      rst = 1'b1;
      #1;
      chk_idle("arst");
      chk("arst_level", 32'(fifo_level), 32'd0);
      chk("arst_ready", 32'(bus.in_ready), 32'd1);
      tick();
      rst = 1'b0;
      mon_q.delete();
      repeat (30) tick();
      chk("post_rst_bits", 32'(mon_q.size()), 32'd0);
      chk_idle("post_rst");
      chk("post_rst_lvl", 32'(fifo_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
